multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the execute datapath (ALU control, ALU, branch unit). It owns the program counter and the instruction register, fetches over a valid/request handshake, and decodes the opcode. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB, driving the `aluop`, `alusrc`, `branch`, register-write and data-memory controls. Branch resolution comes back from the branch unit as `muxcontrol`/`pc_branch`.

---
 rtl/multicycle_ctrl.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Multi-cycle sequencer for the execute datapath. Owns the program counter and
// the instruction register, fetches over a request/valid handshake, decodes the
// opcode class and steps every instruction through FETCH/DECODE/EXEC/MEM/WB,
// driving the ALU, branch, register-write and data-memory controls.
//
// Optional feature macro: MULTICYCLE_ILLEGAL_TRAP_EN
//   defined   : an illegal opcode sets the sticky 'illegal' flag and parks the
//               sequencer in HALT until reset.
//   undefined : an illegal opcode retires as a NOP; 'illegal' is tied to 0.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_req          fetch request (state FETCH)
//   imem_valid/rdata  fetched instruction word and its valid strobe
//   dmem_req/we       data access request (state MEM) and store/load select
//   dmem_ready        data access completes this cycle
//   muxcontrol        branch taken, from the branch unit
//   pc_branch         branch target, from the branch unit
//   pc, ir            current PC and instruction register
//   aluop, alusrc     ALU control class and immediate-operand select
//   branch            branch instruction in flight
//   regwrite          one-cycle register-file write strobe (state WB)
//   memtoreg          write-back source is load data
//   instret           retired-instruction counter
//   illegal           sticky illegal-opcode flag
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        muxcontrol,
  input  logic [31:0] pc_branch,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [1:0]  aluop,
  output logic        alusrc,
  output logic        branch,
  output logic        regwrite,
  output logic        memtoreg,
  output logic [31:0] instret,
  output logic        illegal
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_CMP  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    ,S_HALT
`endif
  } state_e;

  typedef enum logic [2:0] {
    CLS_ILL,
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH
  } cls_e;

  state_e      state_q,    state_d;
  cls_e        cls_q,      cls_d;
  cls_e        dec_cls;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] ir_q,       ir_d;
  logic [31:0] instret_q,  instret_d;
  logic [1:0]  aluop_q,    aluop_d;
  logic        alusrc_q,   alusrc_d;
  logic        branch_q,   branch_d;
  logic        memtoreg_q, memtoreg_d;
  logic        retire;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;  // wraps modulo 2^32 by width

  // Opcode class of the held instruction.
  always_comb begin
    case (ir_q[6:0])
      OPC_R:      dec_cls = CLS_R;
      OPC_I_ALU:  dec_cls = CLS_I;
      OPC_LOAD:   dec_cls = CLS_LOAD;
      OPC_STORE:  dec_cls = CLS_STORE;
      OPC_BRANCH: dec_cls = CLS_BRANCH;
      default:    dec_cls = CLS_ILL;
    endcase
  end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  // Next-state and next-register logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    state_d    = state_q;
    cls_d      = cls_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    instret_d  = instret_q;
    aluop_d    = aluop_q;
    alusrc_d   = alusrc_q;
    branch_d   = branch_q;
    memtoreg_d = memtoreg_q;
    retire     = 1'b0;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    illegal_d  = illegal_q;
`endif

    case (state_q)
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        cls_d   = dec_cls;
        state_d = S_EXEC;
        case (dec_cls)
          CLS_R: begin
            aluop_d  = ALUOP_FUNC;
            alusrc_d = 1'b0;
          end
          CLS_I: begin
            aluop_d  = ALUOP_FUNC;
            alusrc_d = 1'b1;
          end
          CLS_LOAD: begin
            aluop_d    = ALUOP_ADD;
            alusrc_d   = 1'b1;
            memtoreg_d = 1'b1;
          end
          CLS_STORE: begin
            aluop_d  = ALUOP_ADD;
            alusrc_d = 1'b1;
          end
          CLS_BRANCH: begin
            aluop_d  = ALUOP_CMP;
            alusrc_d = 1'b0;
            branch_d = 1'b1;
          end
          default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            illegal_d = 1'b1;
            state_d   = S_HALT;
`endif
          end
        endcase
      end

      S_EXEC: begin
        case (cls_q)
          CLS_BRANCH: begin
            // Branch-unit result is only looked at on this edge.
            pc_d    = muxcontrol ? pc_branch : pc_plus4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          CLS_R, CLS_I:        state_d = S_WB;
          default: begin
            // Illegal opcode without the trap: behaves as a NOP.
            pc_d    = pc_plus4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end

      S_MEM: begin
        if (dmem_ready) begin
          if (cls_q == CLS_STORE) begin
            pc_d    = pc_plus4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        pc_d    = pc_plus4;
        retire  = 1'b1;
        state_d = S_FETCH;
      end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_HALT: state_d = S_HALT;
`endif

      default: state_d = S_FETCH;
    endcase

    // Retirement bumps the counter and clears the decoded controls so they
    // read 0 throughout the next FETCH.
    if (retire) begin
      instret_d  = instret_q + 32'd1;
      aluop_d    = 2'b00;
      alusrc_d   = 1'b0;
      branch_d   = 1'b0;
      memtoreg_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers update with non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    if (!rst_n) begin
      state_q    <= S_FETCH;
      cls_q      <= CLS_ILL;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      instret_q  <= '0;
      aluop_q    <= 2'b00;
      alusrc_q   <= 1'b0;
      branch_q   <= 1'b0;
      memtoreg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      instret_q  <= instret_d;
      aluop_q    <= aluop_d;
      alusrc_q   <= alusrc_d;
      branch_q   <= branch_d;
      memtoreg_q <= memtoreg_d;
    end
  end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Outputs come from registers or from the state register only; no
  // handshake input reaches an output combinationally.
  assign imem_req = (state_q == S_FETCH);
  assign dmem_req = (state_q == S_MEM);
  assign dmem_we  = (state_q == S_MEM) && (cls_q == CLS_STORE);
  assign regwrite = (state_q == S_WB);
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign instret  = instret_q;
  assign aluop    = aluop_q;
  assign alusrc   = alusrc_q;
  assign branch   = branch_q;
  assign memtoreg = memtoreg_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. The driver issues one instruction at a
// time and pushes the expected retirement record into a queue; an independent
// monitor watches the DUT outputs every cycle and, whenever 'instret' moves,
// pops the record and compares PC, IR, counter, cycle count, write-back strobe
// timing, data-request length and control levels.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [31:0] I_ADD  = 32'h002081B3;  // add  x3,x1,x2
  localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] I_LW   = 32'h0000A283;  // lw   x5,0(x1)
  localparam logic [31:0] I_SW   = 32'h0050A223;  // sw   x5,4(x1)
  localparam logic [31:0] I_BEQ  = 32'h00208463;  // beq  x1,x2,+8
  localparam logic [31:0] I_BAD  = 32'h0000007F;  // opcode 1111111

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        muxcontrol;
  logic [31:0] pc_branch;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [1:0]  aluop;
  logic        alusrc;
  logic        branch;
  logic        regwrite;
  logic        memtoreg;
  logic [31:0] instret;
  logic        illegal;

  multicycle_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ready (dmem_ready),
    .muxcontrol (muxcontrol),
    .pc_branch  (pc_branch),
    .pc         (pc),
    .ir         (ir),
    .aluop      (aluop),
    .alusrc     (alusrc),
    .branch     (branch),
    .regwrite   (regwrite),
    .memtoreg   (memtoreg),
    .instret    (instret),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {K_ILL, K_R, K_I, K_LD, K_ST, K_BR} kind_e;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] instret;
    int          cycles;
    int          rw_at;
    int          dm_cycles;
    logic [1:0]  aluop;
    logic        alusrc;
    logic        branch;
    logic        memtoreg;
    logic        we;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] cur_pc   = RESET_PC;
  logic [31:0] exp_ret  = '0;
  int          sync_req = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic kind_e kind_of(input logic [31:0] w);
    case (w[6:0])
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b1100011: return K_BR;
      default:    return K_ILL;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: accumulates per-instruction observations, compares on retirement.
  // ---------------------------------------------------------------------------
  int          m_cyc, m_rw_cnt, m_rw_at, m_dm;
  logic [1:0]  m_aluop;
  logic        m_alusrc, m_branch, m_memtoreg, m_we;
  logic [31:0] m_last;
  int          m_sync_seen = 0;

  task automatic m_clear();
    m_cyc      = 0;
    m_rw_cnt   = 0;
    m_rw_at    = -1;
    m_dm       = 0;
    m_aluop    = 2'b00;
    m_alusrc   = 1'b0;
    m_branch   = 1'b0;
    m_memtoreg = 1'b0;
    m_we       = 1'b0;
  endtask

  initial begin
    exp_t e;
    m_clear();
    m_last = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_clear();
        m_last = instret;
      end else begin
        if (sync_req != m_sync_seen) begin
          m_sync_seen = sync_req;
          m_last      = instret;
          m_clear();
        end else if (instret !== m_last) begin
          if (exp_q.size() == 0) begin
            check("retire_without_expectation", 64'(instret), 64'(m_last));
          end else begin
            e = exp_q.pop_front();
            check("pc",             64'(pc),       64'(e.pc));
            check("ir",             64'(ir),       64'(e.ir));
            check("instret",        64'(instret),  64'(e.instret));
            check("cycles",         64'(m_cyc),    64'(e.cycles));
            check("regwrite_count", 64'(m_rw_cnt), 64'((e.rw_at >= 0) ? 1 : 0));
            check("regwrite_cycle", 64'(m_rw_at),  64'(e.rw_at));
            check("dmem_req_cycles", 64'(m_dm),    64'(e.dm_cycles));
            check("controls", 64'({m_aluop, m_alusrc, m_branch, m_memtoreg, m_we}),
                  64'({e.aluop, e.alusrc, e.branch, e.memtoreg, e.we}));
          end
          m_last = instret;
          m_clear();
        end
        m_cyc++;
        if (regwrite) begin
          m_rw_cnt++;
          m_rw_at = m_cyc - 1;
        end
        if (dmem_req) m_dm++;
        m_aluop    = m_aluop | aluop;
        m_alusrc   = m_alusrc | alusrc;
        m_branch   = m_branch | branch;
        m_memtoreg = m_memtoreg | memtoreg;
        m_we       = m_we | dmem_we;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: called on a negedge with the DUT in FETCH; returns on the negedge
  // of the next FETCH. Completion inputs are deliberately asserted outside
  // their states to show they are ignored.
  // ---------------------------------------------------------------------------
  task automatic run_instr(input logic [31:0] instr, input int fwait, input int mwait,
                           input logic mc, input logic [31:0] tgt);
    exp_t  e;
    kind_e k;
    int    base;
    logic  mem, wb;
    k    = kind_of(instr);
    mem  = (k == K_LD) || (k == K_ST);
    wb   = (k == K_R) || (k == K_I) || (k == K_LD);
    case (k)
      K_R, K_I, K_ST: base = 4;
      K_LD:           base = 5;
      default:        base = 3;
    endcase
    e.cycles    = base + fwait + (mem ? mwait : 0);
    e.rw_at     = wb ? e.cycles - 1 : -1;
    e.dm_cycles = mem ? 1 + mwait : 0;
    e.aluop     = (k == K_R || k == K_I) ? 2'b10 : (k == K_BR) ? 2'b01 : 2'b00;
    e.alusrc    = (k == K_I) || mem;
    e.branch    = (k == K_BR);
    e.memtoreg  = (k == K_LD);
    e.we        = (k == K_ST);
    cur_pc      = (k == K_BR && mc) ? tgt : cur_pc + 32'd4;
    exp_ret     = exp_ret + 32'd1;
    e.pc        = cur_pc;
    e.instret   = exp_ret;
    e.ir        = instr;
    exp_q.push_back(e);

    for (int i = 0; i < fwait; i++) begin
      imem_valid = 1'b0;
      dmem_ready = 1'b1;
      muxcontrol = 1'b1;
      pc_branch  = 32'hDEAD_BEE0;
      @(negedge clk);
    end
    dmem_ready = 1'b0;
    muxcontrol = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = instr;
    @(negedge clk);                       // DECODE
    imem_valid = 1'b0;
    imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);                       // EXEC
    muxcontrol = mc;
    pc_branch  = tgt;
    @(negedge clk);
    muxcontrol = 1'b0;
    pc_branch  = '0;
    if (mem) begin
      for (int i = 0; i < mwait; i++) begin
        dmem_ready = 1'b0;
        imem_valid = 1'b1;
        @(negedge clk);
      end
      imem_valid = 1'b0;
      dmem_ready = 1'b1;
      @(negedge clk);
      dmem_ready = 1'b0;
    end
    if (wb) @(negedge clk);
  endtask

  // Reset values of every control output, packed:
  // {imem_req, dmem_req, dmem_we, regwrite, aluop, alusrc, branch, memtoreg, illegal}
  function automatic logic [9:0] ctrl_vec();
    return {imem_req, dmem_req, dmem_we, regwrite, aluop, alusrc, branch, memtoreg, illegal};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    dmem_ready = 1'b0;
    muxcontrol = 1'b0;
    pc_branch  = '0;
    repeat (2) @(negedge clk);
    check("reset_pc",       64'(pc),         64'(RESET_PC));
    check("reset_ir",       64'(ir),         64'(0));
    check("reset_instret",  64'(instret),    64'(0));
    check("reset_controls", 64'(ctrl_vec()), 64'(10'b10_0000_0000));

    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("imem_req_cycle0", 64'(imem_req), 64'(1));

    run_instr(I_ADD,  0, 0, 1'b0, 32'h0);          // pc 0 -> 4, 4 cycles
    run_instr(I_ADDI, 2, 0, 1'b1, 32'h1234_5678);  // fetch waits, mux ignored
    run_instr(I_BEQ,  0, 0, 1'b1, 32'h0000_0010);  // 8 -> 0x10
    run_instr(I_BEQ,  0, 0, 1'b1, 32'h0000_0040);  // 0x10 taken -> 0x40
    run_instr(I_BEQ,  0, 0, 1'b1, 32'h0000_0010);  // back to 0x10
    run_instr(I_BEQ,  0, 0, 1'b0, 32'h0000_0080);  // 0x10 not taken -> 0x14
    run_instr(I_SW,   0, 0, 1'b0, 32'h0);          // 4-cycle store
    run_instr(I_LW,   0, 3, 1'b0, 32'h0);          // 8 cycles, dmem_req x4
    run_instr(I_SW,   1, 2, 1'b0, 32'h0);
    run_instr(I_LW,   0, 0, 1'b0, 32'h0);          // 5-cycle load, pc 0x24

    // Reset in MEM of a LOAD: no write-back, no retirement.
    imem_valid = 1'b1;
    imem_rdata = I_LW;
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dmem_ready = 1'b0;
    check("abort_in_mem", 64'(dmem_req), 64'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("abort_pc",       64'(pc),         64'(RESET_PC));
    check("abort_instret",  64'(instret),    64'(0));
    check("abort_controls", 64'(ctrl_vec()), 64'(10'b10_0000_0000));
    @(posedge clk);
    #2 rst_n = 1'b1;
    cur_pc  = RESET_PC;
    exp_ret = '0;
    @(negedge clk);
    run_instr(I_ADDI, 0, 0, 1'b0, 32'h0);          // fetch resumes at RESET_PC

`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
    run_instr(I_BAD,  0, 0, 1'b1, 32'h0000_0100);  // NOP: pc+4, retires
`endif

    // PC wrap.
    run_instr(I_BEQ,  0, 0, 1'b1, 32'hFFFF_FFFC);
    run_instr(I_ADD,  0, 0, 1'b0, 32'h0);          // 0xFFFF_FFFC -> 0

    // Counter wrap: preset the retired count, then retire one more.
    @(posedge clk);
    #1 force dut.instret_q = 32'hFFFF_FFFF;
    sync_req++;
    exp_ret = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    @(negedge clk);
    run_instr(I_ADD,  0, 0, 1'b0, 32'h0);          // instret -> 0

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    // Illegal opcode traps into HALT until reset.
    imem_valid = 1'b1;
    imem_rdata = I_BAD;
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      imem_valid = 1'b1;
      dmem_ready = 1'b1;
      check("halt_illegal", 64'(illegal), 64'(1));
      check("halt_pc",      64'(pc),      64'(cur_pc));
      check("halt_strobes", 64'({imem_req, dmem_req, regwrite}), 64'(0));
      @(negedge clk);
    end
    imem_valid = 1'b0;
    dmem_ready = 1'b0;
    check("halt_instret", 64'(instret), 64'(exp_ret));
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("halt_reset_illegal", 64'(illegal), 64'(0));
    check("halt_reset_pc",      64'(pc),      64'(RESET_PC));
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
